// File: rtl/pipe_stage_chain_pkg.sv
// pipe_stage_chain_pkg: shared constants and the stage-action type of the pipeline register chain.
package pipe_stage_chain_pkg;
  localparam int DEF_STAGES = 4;
  localparam int DEF_PW = 128;
  localparam int DEF_DW = 32;
  localparam int DEF_RW = 5;
  localparam int RW_ZERO = 0;
  typedef enum logic [1:0] {ACT_ADV, ACT_HOLD, ACT_KILL} stage_act_e;
endpackage

// File: rtl/pipe_stage_chain_fwd_lookup.sv
// pipe_fwd_lookup: youngest-first register match over all in-flight stage entries for one source port.
module pipe_fwd_lookup
  import pipe_stage_chain_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int DW = DEF_DW,
  parameter int RW = DEF_RW
) (
  input  logic [STAGES-1:0]         e_valid,
  input  logic [STAGES-1:0]         e_wen,
  input  logic [STAGES-1:0]         e_rdy,
  input  logic [STAGES-1:0][RW-1:0] e_rd,
  input  logic [STAGES-1:0][DW-1:0] e_data,
  input  logic [RW-1:0]             rs,
  output logic                      hit,
  output logic [DW-1:0]             data,
  output logic                      pend
);
  always_comb begin
    hit = 1'b0;
    data = '0;
    pend = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--)
      if (e_valid[k] && e_wen[k] && e_rd[k] == rs && rs != RW'(RW_ZERO)) begin
        hit = e_rdy[k];
        data = e_rdy[k] ? e_data[k] : '0;
        pend = ~e_rdy[k];
      end
  end
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: N-stage pipeline register chain with stall, flush, result capture and forwarding.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int PW = DEF_PW,
  parameter int DW = DEF_DW,
  parameter int RW = DEF_RW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [PW-1:0]        in_payload,
  input  logic [RW-1:0]        in_rd,
  input  logic                 in_wen,
  output logic                 in_ready,
  input  logic [STAGES-1:0]    stall,
  input  logic [STAGES-1:0]    flush,
  input  logic [STAGES-1:0]    res_we,
  input  logic [STAGES*DW-1:0] res_data,
  output logic [STAGES-1:0]    stg_valid,
  output logic [STAGES*PW-1:0] stg_payload,
  input  logic [2*RW-1:0]      fwd_rs,
  output logic [1:0]           fwd_hit,
  output logic [2*DW-1:0]      fwd_data,
  output logic                 fwd_stall,
  output logic                 wb_valid,
  output logic [RW-1:0]        wb_rd,
  output logic [DW-1:0]        wb_data
);
  logic [STAGES-1:0] v, wen, rdy, hold, kill, cap;
  logic [STAGES-1:0][RW-1:0] rd;
  logic [STAGES-1:0][PW-1:0] pay;
  logic [STAGES-1:0][DW-1:0] dat, rdat;
  logic [1:0] pend;
  assign rdat = res_data;
  assign cap = res_we & v;
  // hold[k]: some stage at or above k stalls; kill[k]: some flush at or above k
  always_comb begin
    hold = '0;
    kill = '0;
    for (int k = 0; k < STAGES; k++) begin
      hold[k] = |(stall >> k);
      kill[k] = |(flush >> k);
    end
  end
  for (genvar g = 0; g < STAGES; g++) begin : stg
    logic v_d, v_q, wen_d, wen_q, rdy_d, rdy_q, sv, swen, srdy;
    logic [RW-1:0] rd_d, rd_q, srd;
    logic [PW-1:0] pay_d, pay_q, spay;
    logic [DW-1:0] dat_d, dat_q, sdat;
    stage_act_e act;
    if (g == 0) begin : src
      assign sv = in_valid;
      assign swen = in_wen;
      assign srd = in_rd;
      assign spay = in_payload;
      assign srdy = 1'b0;
      assign sdat = '0;
    end else begin : src
      assign sv = v[g-1] & ~hold[g-1] & ~kill[g-1];
      assign swen = wen[g-1];
      assign srd = rd[g-1];
      assign spay = pay[g-1];
      assign srdy = rdy[g-1] | cap[g-1];
      assign sdat = cap[g-1] ? rdat[g-1] : dat[g-1];
    end
    assign act = kill[g] ? ACT_KILL : hold[g] ? ACT_HOLD : ACT_ADV;
    always_comb begin
      v_d = act == ACT_KILL ? 1'b0 : act == ACT_HOLD ? v_q : sv;
      wen_d = act == ACT_HOLD ? wen_q : swen;
      rd_d = act == ACT_HOLD ? rd_q : srd;
      pay_d = act == ACT_HOLD ? pay_q : spay;
      rdy_d = act == ACT_HOLD ? (rdy_q | cap[g]) : srdy;
      dat_d = act == ACT_HOLD ? (cap[g] ? rdat[g] : dat_q) : sdat;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v_q <= 1'b0;
        wen_q <= 1'b0;
        rdy_q <= 1'b0;
        rd_q <= '0;
        pay_q <= '0;
        dat_q <= '0;
      end else begin
        v_q <= v_d;
        wen_q <= wen_d;
        rdy_q <= rdy_d;
        rd_q <= rd_d;
        pay_q <= pay_d;
        dat_q <= dat_d;
      end
    assign v[g] = v_q;
    assign wen[g] = wen_q;
    assign rdy[g] = rdy_q;
    assign rd[g] = rd_q;
    assign pay[g] = pay_q;
    assign dat[g] = dat_q;
  end
  for (genvar p = 0; p < 2; p++) begin : fwd
    pipe_fwd_lookup #(.STAGES(STAGES), .DW(DW), .RW(RW)) u_lookup (
      .e_valid(v),
      .e_wen(wen),
      .e_rdy(rdy),
      .e_rd(rd),
      .e_data(dat),
      .rs(fwd_rs[p*RW +: RW]),
      .hit(fwd_hit[p]),
      .data(fwd_data[p*DW +: DW]),
      .pend(pend[p])
    );
  end
  assign fwd_stall = |pend;
  assign in_ready = ~|stall;
  assign stg_valid = v;
  assign stg_payload = pay;
  assign wb_valid = v[STAGES-1] & wen[STAGES-1] & rdy[STAGES-1];
  assign wb_rd = rd[STAGES-1];
  assign wb_data = dat[STAGES-1];
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed and random checks of pipe_stage_chain against an entry-level model.
module tb_pipe_stage_chain;
  localparam int S = 4;
  localparam int PW = 128;
  localparam int DW = 32;
  localparam int RW = 5;
  logic clk = 0, rst = 1, in_valid = 0, in_wen = 0;
  logic [PW-1:0] in_payload = '0;
  logic [RW-1:0] in_rd = '0;
  logic in_ready, fwd_stall, wb_valid;
  logic [S-1:0] stall = '0, flush = '0, res_we = '0, stg_valid;
  logic [S*DW-1:0] res_data = '0;
  logic [S*PW-1:0] stg_payload;
  logic [2*RW-1:0] fwd_rs = '0;
  logic [1:0] fwd_hit;
  logic [2*DW-1:0] fwd_data;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  int checks = 0, failures = 0;
  typedef struct {
    logic v;
    logic [PW-1:0] pay;
    logic [RW-1:0] rd;
    logic wen;
    logic rdy;
    logic [DW-1:0] data;
  } ent_t;
  ent_t m[S];
  logic [PW-1:0] saved;

  pipe_stage_chain #(.STAGES(S), .PW(PW), .DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_payload(in_payload), .in_rd(in_rd),
    .in_wen(in_wen), .in_ready(in_ready), .stall(stall), .flush(flush), .res_we(res_we),
    .res_data(res_data), .stg_valid(stg_valid), .stg_payload(stg_payload), .fwd_rs(fwd_rs),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < S; k++) m[k] = '{1'b0, '0, '0, 1'b0, 1'b0, '0};
  endtask

  task automatic check_all();
    logic pend_any;
    pend_any = 1'b0;
    chk("in_ready", in_ready, stall == '0);
    for (int k = 0; k < S; k++) begin
      chk($sformatf("valid%0d", k), stg_valid[k], m[k].v);
      if (m[k].v) chk($sformatf("payload%0d", k), stg_payload[k*PW +: PW], m[k].pay);
    end
    chk("wb_valid", wb_valid, m[S-1].v && m[S-1].wen && m[S-1].rdy);
    if (m[S-1].v && m[S-1].wen && m[S-1].rdy) begin
      chk("wb_rd", wb_rd, m[S-1].rd);
      chk("wb_data", wb_data, m[S-1].data);
    end
    for (int p = 0; p < 2; p++) begin
      logic [RW-1:0] rs;
      logic found, hit;
      logic [DW-1:0] d;
      rs = fwd_rs[p*RW +: RW];
      found = 1'b0;
      hit = 1'b0;
      d = '0;
      for (int k = 0; k < S; k++)
        if (!found && rs != 0 && m[k].v && m[k].wen && m[k].rd == rs) begin
          found = 1'b1;
          hit = m[k].rdy;
          d = hit ? m[k].data : '0;
          pend_any = pend_any | !hit;
        end
      chk($sformatf("fwd_hit%0d", p), fwd_hit[p], hit);
      chk($sformatf("fwd_data%0d", p), fwd_data[p*DW +: DW], d);
    end
    chk("fwd_stall", fwd_stall, pend_any);
  endtask

  // Results attach to their entry first, then entries move by the hold point / flush point rules.
  task automatic step();
    ent_t c[S], n[S];
    int h, f;
    #1;
    check_all();
    h = -1;
    f = -1;
    for (int k = 0; k < S; k++) begin
      if (stall[k]) h = k;
      if (flush[k]) f = k;
    end
    c = m;
    for (int k = 0; k < S; k++)
      if (res_we[k] && m[k].v) begin
        c[k].rdy = 1'b1;
        c[k].data = res_data[k*DW +: DW];
      end
    for (int k = 0; k < S; k++) begin
      if (k <= f) begin
        n[k] = c[k];
        n[k].v = 1'b0;
      end else if (k <= h) n[k] = c[k];
      else if (h >= 0 && k == h + 1) begin
        n[k] = c[k];
        n[k].v = 1'b0;
      end else if (k == 0) begin
        n[0].v = in_valid;
        n[0].pay = in_payload;
        n[0].rd = in_rd;
        n[0].wen = in_wen;
        n[0].rdy = 1'b0;
        n[0].data = '0;
      end else begin
        n[k] = c[k-1];
        if (k - 1 <= f) n[k].v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic feed(input logic [RW-1:0] r);
    in_valid = 1'b1;
    in_rd = r;
    in_wen = 1'b1;
    in_payload = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle();
    in_valid = 1'b0;
    stall = '0;
    flush = '0;
    res_we = '0;
  endtask

  initial begin
    model_clear();
    #3;
    chk("rst_valid", stg_valid, '0);
    chk("rst_payload", stg_payload[PW-1:0], '0);
    chk("rst_wb", wb_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_fwd", {fwd_stall, fwd_hit}, '0);
    #10 rst = 0;
    // flow: rd=1..6 back to back, result in stage 1 = rd*16
    for (int j = 1; j <= 9; j++) begin
      if (j <= 6) feed(RW'(j)); else in_valid = 1'b0;
      res_we = 4'b0010;
      res_data[DW +: DW] = DW'(m[1].rd) * 16;
      step();
      if (j >= 4) begin
        chk("flow_wb_valid", wb_valid, 1'b1);
        chk("flow_wb_rd", wb_rd, RW'(j - 3));
        chk("flow_wb_data", wb_data, DW'((j - 3) * 16));
      end
    end
    idle();
    step();
    // stall[1] for two cycles
    for (int j = 1; j <= 3; j++) begin
      feed(RW'(j + 8));
      step();
    end
    feed(RW'(12));
    stall = 4'b0010;
    #1 chk("stall_ready0", in_ready, 1'b0);
    step();
    chk("stall_bubble0", stg_valid[2], 1'b0);
    chk("stall_ready1", in_ready, 1'b0);
    step();
    chk("stall_bubble1", stg_valid, 4'b0011);
    stall = '0;
    for (int j = 0; j < 5; j++) begin
      if (j == 1) feed(RW'(13)); else if (j > 1) in_valid = 1'b0;
      step();
    end
    // flush[1] together with stall[2]
    for (int j = 1; j <= 3; j++) begin
      feed(RW'(j + 16));
      step();
    end
    saved = stg_payload[2*PW +: PW];
    flush = 4'b0010;
    stall = 4'b0100;
    step();
    chk("flush_low", stg_valid[1:0], 2'b00);
    chk("flush_hold", stg_valid[2], 1'b1);
    chk("flush_pay", stg_payload[2*PW +: PW], saved);
    idle();
    flush = 4'b1111;
    step();
    idle();
    // forwarding priority: younger pending beats older ready
    feed(RW'(3));
    step();
    feed(RW'(3));
    step();
    in_valid = 1'b0;
    res_we = 4'b0010;
    res_data[DW +: DW] = 32'hAA;
    step();
    res_we = '0;
    fwd_rs = {RW'(0), RW'(3)};
    #1;
    chk("fwd_pend_stall", fwd_stall, 1'b1);
    chk("fwd_pend_hit", fwd_hit, 2'b00);
    stall = 4'b0010;
    res_we = 4'b0010;
    res_data[DW +: DW] = 32'hBB;
    step();
    chk("fwd_bb_hit", fwd_hit, 2'b01);
    chk("fwd_bb_data", fwd_data, {32'h0, 32'hBB});
    chk("fwd_bb_stall", fwd_stall, 1'b0);
    idle();
    flush = 4'b1111;
    step();
    idle();
    // hold capture of 0x55
    feed(RW'(5));
    step();
    in_valid = 1'b0;
    step();
    stall = 4'b0010;
    res_we = 4'b0010;
    res_data[DW +: DW] = 32'h55;
    fwd_rs = {RW'(5), RW'(5)};
    step();
    chk("hold_valid", stg_valid[1], 1'b1);
    chk("hold_fwd", {fwd_hit, fwd_data}, {2'b11, 32'h55, 32'h55});
    idle();
    // random traffic against the model
    for (int j = 0; j < 400; j++) begin
      in_valid = 1'($urandom);
      in_rd = RW'($urandom_range(0, 7));
      in_wen = 1'($urandom);
      in_payload = {$urandom, $urandom, $urandom, $urandom};
      stall = ($urandom_range(0, 3) == 0) ? S'($urandom) : '0;
      flush = ($urandom_range(0, 15) == 0) ? S'($urandom) : '0;
      res_we = S'($urandom);
      res_data = {$urandom, $urandom, $urandom, $urandom};
      fwd_rs = {RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7))};
      step();
      if (j == 200) begin
        stall = '0;
        flush = '0;
        rst = 1'b1;
        #1;
        chk("arst_valid", stg_valid, '0);
        chk("arst_wb", wb_valid, 1'b0);
        chk("arst_ready", in_ready, 1'b1);
        model_clear();
        rst = 1'b0;
      end
    end
    idle();
    step();
    check_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
